// File: rtl/alu_share_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_if
// Description : Bundle of the two request channels, the shared response
//               channel and the ALU drive/return signals of
//               alu_share_arbiter.
//               slave  - arbiter side (accepts requests, drives ALU/response)
//               master - environment side (requesters, consumer, ALU)
// Ports       : req0_*/req1_* : valid/ready request channels (a, b, op)
//               resp_*        : valid/ready response channel (id, result,
//                               zero, err)
//               alu_*         : operand/control drive and result/zero return
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic             resp_err;

    logic [WIDTH-1:0] alu_src_a;
    logic [WIDTH-1:0] alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_id, resp_result, resp_zero, resp_err,
        input  resp_ready,
        output alu_src_a, alu_src_b, alu_ctrl,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_err,
        output resp_ready,
        input  alu_src_a, alu_src_b, alu_ctrl,
        output alu_result, alu_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters. A request is accepted in IDLE, the ALU is driven
//               from the latched operands for one cycle (EXEC), and the
//               captured result is presented on the response channel (RESP)
//               until consumed. One operation is in flight at a time.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - alu_share_if.slave (request, response, ALU signals)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int       WIDTH  = 32,
    parameter logic [2:0] OP_AND = 3'b000,
    parameter logic [2:0] OP_OR  = 3'b001,
    parameter logic [2:0] OP_ADD = 3'b010,
    parameter logic [2:0] OP_SUB = 3'b110,
    parameter logic [2:0] OP_SLT = 3'b111
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_share_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [2:0]       op_code_q, op_code_d;
    logic             op_id_q, op_id_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             resp_id_q, resp_id_d;
    logic             resp_err_q, resp_err_d;

    logic             grant0;
    logic             grant1;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // A lone valid wins outright; on a tie prio_q picks the requester.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
    assign grant1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);

    assign bus.req0_ready = (state_q == IDLE) && grant0;
    assign bus.req1_ready = (state_q == IDLE) && grant1;

    // ALU drive always reflects the latched request; an illegal code is
    // replaced by AND so the ALU never sees an undefined control value.
    assign bus.alu_src_a = op_a_q;
    assign bus.alu_src_b = op_b_q;
    assign bus.alu_ctrl  = err_q ? OP_AND : op_code_q;

    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = res_q;
    assign bus.resp_zero   = zero_q;
    assign bus.resp_err    = resp_err_q;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_code_d  = op_code_q;
        op_id_d    = op_id_q;
        err_d      = err_q;
        res_d      = res_q;
        zero_d     = zero_q;
        resp_id_d  = resp_id_q;
        resp_err_d = resp_err_q;

        case (state_q)
            IDLE: begin
                if (grant0) begin
                    op_a_d    = bus.req0_a;
                    op_b_d    = bus.req0_b;
                    op_code_d = bus.req0_op;
                    op_id_d   = 1'b0;
                    err_d     = !op_legal(bus.req0_op);
                    state_d   = EXEC;
                end else if (grant1) begin
                    op_a_d    = bus.req1_a;
                    op_b_d    = bus.req1_b;
                    op_code_d = bus.req1_op;
                    op_id_d   = 1'b1;
                    err_d     = !op_legal(bus.req1_op);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                res_d      = err_q ? '0   : bus.alu_result;
                zero_d     = err_q ? 1'b0 : bus.alu_zero;
                resp_id_d  = op_id_q;
                resp_err_d = err_q;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    // The requester just served drops to low priority.
                    prio_d  = ~op_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_code_q  <= OP_AND;
            op_id_q    <= 1'b0;
            err_q      <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            resp_id_q  <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_code_q  <= op_code_d;
            op_id_q    <= op_id_d;
            err_q      <= err_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            resp_id_q  <= resp_id_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester, round-robin arbiter that time-shares the single combinational 32-bit ALU between two clients, such as an integer pipe and a branch/compare unit. Each client issues operand pairs and a 3-bit ALU control code over a valid/ready handshake. The block registers the request and drives the ALU for one cycle. It then captures the result and zero flag and returns them on a shared response channel, tagged with the requester ID.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- OP_AND/OP_OR/OP_ADD/OP_SUB/OP_SLT, 3'b000/3'b001/3'b010/3'b110/3'b111, legal ALU control codes

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle when high with valid
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  3  requester 0 ALU control code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths and meaning for requester 1
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that owns the response
- resp_result  out  WIDTH  captured ALU result
- resp_zero  out  1  captured ALU zero flag
- resp_err  out  1  request carried an illegal op code
- alu_src_a, alu_src_b  out  WIDTH  ALU operand drive
- alu_ctrl  out  3  ALU control drive
- alu_result  in  WIDTH  ALU result (combinational from alu_* outputs)
- alu_zero  in  1  ALU zero flag

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from req0_valid, req1_valid and the priority pointer prio (reset 0, meaning requester 0 is preferred).
  - Only one readyN is high at a time: the granted requester's.
  - If only one valid is high, that requester is granted regardless of prio.
  - If neither valid is high, both readys are low.
- Accept (valid && ready in IDLE):
  - Latch a, b, op and id into op_a/op_b/op_code/op_id.
  - Set err_q = (op not one of the five legal codes).
  - Go to EXEC.
- EXEC:
  - alu_src_a/alu_src_b/alu_ctrl are driven from the latched registers.
  - At the clock edge, capture res_q <= alu_result and zero_q <= alu_zero, then go to RESP.
  - If err_q is set: res_q <= 0, zero_q <= 0, and alu_ctrl is driven as OP_AND (the ALU is never given an illegal code).
- RESP:
  - resp_valid = 1; resp_id/resp_result/resp_zero/resp_err come from the registers and are held stable until accepted.
  - On resp_ready: go to IDLE and set prio <= ~op_id, so the requester just served loses priority.
- Both readys are low in EXEC and RESP, so no new request can be accepted while one is outstanding.
- alu_* outputs hold the last latched values outside EXEC. After reset they are 0/0/OP_AND.
- Reset (async, any state):
  - state=IDLE, prio=0, all latched registers 0.
  - resp_valid=0, both readys follow IDLE rules with prio=0.
  - An in-flight request is discarded with no response.

## Timing
- Accept at edge N → ALU driven during cycle N..N+1 → result captured at edge N+1 → resp_valid high from after edge N+1.
- Minimum request-to-response latency: 2 cycles.
- Sustained throughput with resp_ready tied high: one operation per 3 cycles (IDLE, EXEC, RESP).
- readyN is combinational from the validN inputs and prio; there is no combinational path from the alu_* inputs to any output.
- resp_* outputs are registered and change only on the EXEC→RESP edge.
- Simultaneous requests alternate strictly: 0,1,0,1…, starting with 0 after reset.
- A valid that is held while not granted must stay pending. Requesters hold valid/a/b/op stable until ready is seen.

## Test plan
- Reset, then req0 ADD a=5 b=7 → req0_ready in the same cycle; resp_valid 2 cycles later with id=0, result=12, zero=0, err=0.
- req1 SUB a=9 b=9 → resp id=1, result=0, zero=1. Then SLT a=3 b=8 → result=1, zero=0.
- Both valid continuously with resp_ready=1, four ops each → responses in order 0,1,0,1,0,1,0,1, each 3 cycles apart, with no requester starved.
- resp_ready held low 5 cycles in RESP → resp_* stay stable, both readys low; response consumed on the cycle resp_ready rises, then IDLE.
- req0 op=3'b011 → resp err=1, result=0, zero=0; alu_ctrl observed as 000 during EXEC.
- rst_n pulsed low during EXEC → resp_valid never asserts for that request; prio=0, so the next simultaneous requests grant requester 0 first.
